// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix encodings and types.
package ahb_mtx_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HBURST encodings
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // HRESP encodings
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Default-slave two-cycle ERROR response states
   typedef enum logic [1:0] {
      DsOkay = 2'b00,
      DsErr1 = 2'b01,
      DsErr2 = 2'b10
   } ds_state_e;

endpackage

// File: rtl/ahb_mtx_input_stage_defslave.sv
// Built-in default slave: two-cycle ERROR response for unmapped transfers.
module ahb_mtx_defslave_resp
   import ahb_mtx_pkg::*;
(
   input  logic HCLK,
   input  logic HRESETn,
   input  logic start,
   output logic busy,
   output logic readyout,
   output logic resp
);

   ds_state_e state_q, state_d;

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= DsOkay;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and response outputs
   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      readyout = 1'b1;
      resp     = HRESP_OKAY;
      unique case (state_q)
         DsOkay: begin
            if (start) state_d = DsErr1;
         end
         DsErr1: begin
            busy     = 1'b1;
            readyout = 1'b0;
            resp     = HRESP_ERROR;
            state_d  = DsErr2;
         end
         DsErr2: begin
            busy    = 1'b1;
            resp    = HRESP_ERROR;
            // A back-to-back unmapped transfer may be accepted in the last cycle
            state_d = start ? DsErr1 : DsOkay;
         end
         default: state_d = DsOkay;
      endcase
   end

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// AHB bus-matrix master-side input stage: holds the address phase until an
// output port accepts it and routes the accepting port's data-phase response.
// Optional default slave for unmapped addresses: AHB_MTX_INSTAGE_DEFSLAVE_EN.
module ahb_mtx_input_stage
   import ahb_mtx_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_OUT    = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELS,
   input  logic [1:0]            HTRANSS,
   input  logic [ADDR_WIDTH-1:0] HADDRS,
   input  logic                  HWRITES,
   input  logic [2:0]            HSIZES,
   input  logic [2:0]            HBURSTS,
   input  logic [3:0]            HPROTS,
   input  logic                  HMASTLOCKS,
   input  logic                  HREADYS,
   output logic                  HREADYOUTS,
   output logic                  HRESPS,
   output logic [1:0]            HTRANSM,
   output logic [ADDR_WIDTH-1:0] HADDRM,
   output logic                  HWRITEM,
   output logic [2:0]            HSIZEM,
   output logic [2:0]            HBURSTM,
   output logic [3:0]            HPROTM,
   output logic                  HMASTLOCKM,
   input  logic [NUM_OUT-1:0]    targ_sel,
   output logic [NUM_OUT-1:0]    req_port,
   input  logic [NUM_OUT-1:0]    addr_accept,
   input  logic [NUM_OUT-1:0]    data_readyout,
   input  logic [NUM_OUT-1:0]    data_resp
);

   logic                  hold_valid_q;
   logic [1:0]            hold_trans_q;
   logic [ADDR_WIDTH-1:0] hold_addr_q;
   logic                  hold_write_q;
   logic [2:0]            hold_size_q;
   logic [2:0]            hold_burst_q;
   logic [3:0]            hold_prot_q;
   logic                  hold_lock_q;
   logic                  dphase_valid_q;
   logic [NUM_OUT-1:0]    dphase_port_q;

   logic                  xfer_s;
   logic [NUM_OUT-1:0]    port_accept;
   logic                  def_accept;
   logic                  accept_any;
   logic                  capture;
   logic                  ds_busy;
   logic                  ds_readyout;
   logic                  ds_resp;

   assign xfer_s = HSELS & HTRANSS[1] & HREADYS;

   // Address-phase mux: held copy takes precedence over the live master
   always_comb begin
      HTRANSM    = HTRANSS;
      HADDRM     = HADDRS;
      HWRITEM    = HWRITES;
      HSIZEM     = HSIZES;
      HBURSTM    = HBURSTS;
      HPROTM     = HPROTS;
      HMASTLOCKM = HMASTLOCKS;
      if (hold_valid_q) begin
         HTRANSM    = hold_trans_q;
         HADDRM     = hold_addr_q;
         HWRITEM    = hold_write_q;
         HSIZEM     = hold_size_q;
         HBURSTM    = hold_burst_q;
         HPROTM     = hold_prot_q;
         HMASTLOCKM = hold_lock_q;
      end else if (!HSELS || !HREADYS) begin
         HTRANSM = HTRANS_IDLE;
      end
   end

   // Locked sequences keep the arbiter claimed through IDLE cycles
   assign req_port = targ_sel & {NUM_OUT{HTRANSM[1] | HMASTLOCKM}};

   // Only NONSEQ/SEQ transfers open a data phase
   assign port_accept = addr_accept & targ_sel & {NUM_OUT{HTRANSM[1]}};

`ifdef AHB_MTX_INSTAGE_DEFSLAVE_EN
   assign def_accept = HTRANSM[1] & ~|targ_sel;

   ahb_mtx_defslave_resp u_defslave (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .start    (def_accept),
      .busy     (ds_busy),
      .readyout (ds_readyout),
      .resp     (ds_resp)
   );
`else
   assign def_accept  = 1'b0;
   assign ds_busy     = 1'b0;
   assign ds_readyout = 1'b1;
   assign ds_resp     = HRESP_OKAY;
`endif

   assign accept_any = (|port_accept) | def_accept;
   assign capture    = xfer_s & ~accept_any & ~hold_valid_q;

   // Hold register: capture a live transfer nobody accepted, release on accept
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_valid_q <= 1'b0;
         hold_trans_q <= HTRANS_IDLE;
         hold_addr_q  <= '0;
         hold_write_q <= 1'b0;
         hold_size_q  <= '0;
         hold_burst_q <= HBURST_SINGLE;
         hold_prot_q  <= '0;
         hold_lock_q  <= 1'b0;
      end else if (capture) begin
         hold_valid_q <= 1'b1;
         hold_trans_q <= HTRANSS;
         hold_addr_q  <= HADDRS;
         hold_write_q <= HWRITES;
         hold_size_q  <= HSIZES;
         hold_burst_q <= HBURSTS;
         hold_prot_q  <= HPROTS;
         hold_lock_q  <= HMASTLOCKS;
      end else if (hold_valid_q && accept_any) begin
         hold_valid_q <= 1'b0;
      end
   end

   // Data-phase tracker: which port owns the current data phase
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dphase_valid_q <= 1'b0;
         dphase_port_q  <= '0;
      end else if (accept_any) begin
         dphase_valid_q <= 1'b1;
         dphase_port_q  <= port_accept;
      end else if (HREADYS) begin
         dphase_valid_q <= 1'b0;
         dphase_port_q  <= '0;
      end
   end

   // Response to master: data-phase owner, else stall while holding, else OKAY
   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = HRESP_OKAY;
      if (ds_busy) begin
         HREADYOUTS = ds_readyout;
         HRESPS     = ds_resp;
      end else if (dphase_valid_q) begin
         HREADYOUTS = |(data_readyout & dphase_port_q);
         HRESPS     = |(data_resp & dphase_port_q);
      end else if (hold_valid_q) begin
         HREADYOUTS = 1'b0;
      end
   end

`ifndef SYNTHESIS
   // Hold and data phase never coexist
   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         assert (!(hold_valid_q && dphase_valid_q))
            else $error("hold_valid and dphase_valid both set");
      end
   end
`ifndef AHB_MTX_INSTAGE_DEFSLAVE_EN
   // Without the default slave an unmapped transfer can never complete
   always_ff @(posedge HCLK) begin
      if (HRESETn && HTRANSM[1] && (targ_sel == '0)) begin
         $error("unmapped transfer at address %h", HADDRM);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed bench for ahb_mtx_input_stage: cycle table plus hand sequences.
module tb_ahb_mtx_input_stage;
   import ahb_mtx_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSELS;
   logic [1:0]  HTRANSS;
   logic [31:0] HADDRS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HMASTLOCKS;
   logic        HREADYS;
   logic        HREADYOUTS;
   logic        HRESPS;
   logic [1:0]  HTRANSM;
   logic [31:0] HADDRM;
   logic        HWRITEM;
   logic [2:0]  HSIZEM;
   logic [2:0]  HBURSTM;
   logic [3:0]  HPROTM;
   logic        HMASTLOCKM;
   logic [3:0]  targ_sel;
   logic [3:0]  req_port;
   logic [3:0]  addr_accept;
   logic [3:0]  data_readyout;
   logic [3:0]  data_resp;

   int total = 0;
   int bad   = 0;

   // Single master: its HREADY is our HREADYOUTS
   assign HREADYS = HREADYOUTS;

   always #5 HCLK = ~HCLK;

   ahb_mtx_input_stage #(
      .ADDR_WIDTH (32),
      .NUM_OUT    (4)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HSELS         (HSELS),
      .HTRANSS       (HTRANSS),
      .HADDRS        (HADDRS),
      .HWRITES       (HWRITES),
      .HSIZES        (HSIZES),
      .HBURSTS       (HBURSTS),
      .HPROTS        (HPROTS),
      .HMASTLOCKS    (HMASTLOCKS),
      .HREADYS       (HREADYS),
      .HREADYOUTS    (HREADYOUTS),
      .HRESPS        (HRESPS),
      .HTRANSM       (HTRANSM),
      .HADDRM        (HADDRM),
      .HWRITEM       (HWRITEM),
      .HSIZEM        (HSIZEM),
      .HBURSTM       (HBURSTM),
      .HPROTM        (HPROTM),
      .HMASTLOCKM    (HMASTLOCKM),
      .targ_sel      (targ_sel),
      .req_port      (req_port),
      .addr_accept   (addr_accept),
      .data_readyout (data_readyout),
      .data_resp     (data_resp)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic [3:0]  targ;
      logic [3:0]  acc;
      logic [3:0]  drdy;
      logic [3:0]  dresp;
      logic        e_rdy;
      logic        e_resp;
      logic [3:0]  e_req;
      logic [1:0]  e_trans;
      logic [31:0] e_addr;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vt [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive just after the rising edge, return at the falling edge
   task automatic apply(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic [3:0] targ, input logic [3:0] acc, input logic [3:0] drdy,
                        input logic [3:0] dresp);
      @(posedge HCLK);
      #1;
      HSELS         = sel;
      HTRANSS       = trans;
      HADDRS        = addr;
      targ_sel      = targ;
      addr_accept   = acc;
      data_readyout = drdy;
      data_resp     = dresp;
      @(negedge HCLK);
   endtask

   initial begin
      HRESETn       = 1'b0;
      HSELS         = 1'b0;
      HTRANSS       = HTRANS_IDLE;
      HADDRS        = '0;
      HWRITES       = 1'b0;
      HSIZES        = 3'd2;
      HBURSTS       = HBURST_SINGLE;
      HPROTS        = 4'h3;
      HMASTLOCKS    = 1'b0;
      targ_sel      = '0;
      addr_accept   = '0;
      data_readyout = 4'hF;
      data_resp     = '0;

      //         sel trans          addr        targ     acc      drdy     dresp    rdy  rsp  req      transm         addrm
      // idle
      vt[0]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      // NONSEQ to port 1, accepted at once; one wait state from the port
      vt[1]  = '{1'b1, HTRANS_NONSEQ, 32'h1000, 4'b0010, 4'b0010, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0010, HTRANS_NONSEQ, 32'h1000};
      vt[2]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1101, 4'b0000, 1'b0, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      vt[3]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      vt[4]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      // NONSEQ to port 2, not accepted for three cycles
      vt[5]  = '{1'b1, HTRANS_NONSEQ, 32'h2040, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0100, HTRANS_NONSEQ, 32'h2040};
      vt[6]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0100, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, HTRANS_NONSEQ, 32'h2040};
      vt[7]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0100, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, HTRANS_NONSEQ, 32'h2040};
      vt[8]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0100, 4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, HTRANS_NONSEQ, 32'h2040};
      vt[9]  = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      // two-cycle ERROR from port 0
      vt[10] = '{1'b1, HTRANS_NONSEQ, 32'h0010, 4'b0001, 4'b0001, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, HTRANS_NONSEQ, 32'h0010};
      vt[11] = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1110, 4'b0001, 1'b0, 1'b1, 4'b0000, HTRANS_IDLE,   32'h0};
      vt[12] = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b1, 4'b0000, HTRANS_IDLE,   32'h0};
      vt[13] = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      // BUSY is neither requested nor captured
      vt[14] = '{1'b1, HTRANS_BUSY,   32'h0030, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_BUSY,   32'h0030};
      vt[15] = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};
      // unselected NONSEQ is forced to IDLE
      vt[16] = '{1'b0, HTRANS_NONSEQ, 32'h0044, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0044};
      vt[17] = '{1'b0, HTRANS_IDLE,   32'h0,    4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, HTRANS_IDLE,   32'h0};

      // reset values
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_readyout", 32'(HREADYOUTS), 32'd1);
      chk("rst_resp", 32'(HRESPS), 32'd0);
      chk("rst_req", 32'(req_port), 32'd0);
      chk("rst_htransm", 32'(HTRANSM), 32'(HTRANS_IDLE));
      HRESETn = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         apply(vt[i].sel, vt[i].trans, vt[i].addr, vt[i].targ, vt[i].acc, vt[i].drdy,
               vt[i].dresp);
         chk($sformatf("v%0d_readyout", i), 32'(HREADYOUTS), 32'(vt[i].e_rdy));
         chk($sformatf("v%0d_resp", i), 32'(HRESPS), 32'(vt[i].e_resp));
         chk($sformatf("v%0d_req", i), 32'(req_port), 32'(vt[i].e_req));
         chk($sformatf("v%0d_htransm", i), 32'(HTRANSM), 32'(vt[i].e_trans));
         chk($sformatf("v%0d_haddrm", i), HADDRM, vt[i].e_addr);
      end

      // INCR4 to port 3: beat 1 held one cycle, beats 2-4 live, one port wait each
      HBURSTS = HBURST_INCR4;
      apply(1'b1, HTRANS_NONSEQ, 32'h100, 4'b1000, 4'b0000, 4'b1111, 4'b0000);
      chk("b1_readyout", 32'(HREADYOUTS), 32'd1);
      chk("b1_req", 32'(req_port), 32'b1000);
      apply(1'b1, HTRANS_SEQ, 32'h104, 4'b1000, 4'b1000, 4'b1111, 4'b0000);
      HBURSTS = HBURST_SINGLE;
      chk("b1h_readyout", 32'(HREADYOUTS), 32'd0);
      chk("b1h_haddrm", HADDRM, 32'h100);
      chk("b1h_hburstm", 32'(HBURSTM), 32'(HBURST_INCR4));
      chk("b1h_htransm", 32'(HTRANSM), 32'(HTRANS_NONSEQ));
      HBURSTS = HBURST_INCR4;
      apply(1'b1, HTRANS_SEQ, 32'h104, 4'b1000, 4'b0000, 4'b0111, 4'b0000);
      chk("b1w_readyout", 32'(HREADYOUTS), 32'd0);
      chk("b1w_htransm", 32'(HTRANSM), 32'(HTRANS_IDLE));
      chk("b1w_req", 32'(req_port), 32'd0);
      for (int b = 0; b < 3; b++) begin
         apply(1'b1, HTRANS_SEQ, 32'h104 + 32'(4 * b), 4'b1000, 4'b1000, 4'b1111, 4'b0000);
         chk($sformatf("b%0d_readyout", b + 2), 32'(HREADYOUTS), 32'd1);
         chk($sformatf("b%0d_haddrm", b + 2), HADDRM, 32'h104 + 32'(4 * b));
         chk($sformatf("b%0d_req", b + 2), 32'(req_port), 32'b1000);
         if (b < 2) begin
            apply(1'b1, HTRANS_SEQ, 32'h108 + 32'(4 * b), 4'b1000, 4'b0000, 4'b0111, 4'b0000);
         end else begin
            apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0000, 4'b0000, 4'b0111, 4'b0000);
         end
         chk($sformatf("b%0d_wait", b + 2), 32'(HREADYOUTS), 32'd0);
      end
      HBURSTS = HBURST_SINGLE;
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
      chk("b4_done", 32'(HREADYOUTS), 32'd1);

      // capture of a new transfer coinciding with completion of the previous data phase
      apply(1'b1, HTRANS_NONSEQ, 32'h20, 4'b0001, 4'b0001, 4'b1111, 4'b0000);
      apply(1'b1, HTRANS_NONSEQ, 32'h24, 4'b0010, 4'b0000, 4'b1111, 4'b0000);
      chk("cc_first_done", 32'(HREADYOUTS), 32'd1);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0010, 4'b0000, 4'b1111, 4'b0000);
      chk("cc_hold_readyout", 32'(HREADYOUTS), 32'd0);
      chk("cc_hold_haddrm", HADDRM, 32'h24);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0010, 4'b0010, 4'b1111, 4'b0000);
      chk("cc_accept_readyout", 32'(HREADYOUTS), 32'd0);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
      chk("cc_done", 32'(HREADYOUTS), 32'd1);

      // reset while holding discards the transfer
      apply(1'b1, HTRANS_NONSEQ, 32'h300, 4'b0100, 4'b0000, 4'b1111, 4'b0000);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0100, 4'b0000, 4'b1111, 4'b0000);
      chk("rh_hold_haddrm", HADDRM, 32'h300);
      HRESETn = 1'b0;
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0100, 4'b0000, 4'b1111, 4'b0000);
      chk("rh_rst_readyout", 32'(HREADYOUTS), 32'd1);
      chk("rh_rst_req", 32'(req_port), 32'd0);
      chk("rh_rst_htransm", 32'(HTRANSM), 32'(HTRANS_IDLE));
      HRESETn = 1'b1;
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0100, 4'b0000, 4'b1111, 4'b0000);
      chk("rh_post_req", 32'(req_port), 32'd0);
      chk("rh_post_readyout", 32'(HREADYOUTS), 32'd1);
      chk("rh_post_haddrm", HADDRM, 32'h0);

`ifdef AHB_MTX_INSTAGE_DEFSLAVE_EN
      // unmapped NONSEQ answered by the default slave
      apply(1'b1, HTRANS_NONSEQ, 32'h900, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
      chk("ds_req", 32'(req_port), 32'd0);
      chk("ds_addr_readyout", 32'(HREADYOUTS), 32'd1);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
      chk("ds_err1_readyout", 32'(HREADYOUTS), 32'd0);
      chk("ds_err1_resp", 32'(HRESPS), 32'd1);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
      chk("ds_err2_readyout", 32'(HREADYOUTS), 32'd1);
      chk("ds_err2_resp", 32'(HRESPS), 32'd1);
      apply(1'b0, HTRANS_IDLE, 32'h0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
      chk("ds_done_resp", 32'(HRESPS), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_mtx_input_stage.md
# ahb_mtx_input_stage

Master-side input stage of the AHB bus matrix. It sits between one AHB-Lite master and the output-stage arbiters. It raises one-hot `req_port` requests toward the output ports and holds the master's address phase in a register until the selected output port accepts it. It also returns the data-phase HREADYOUT/HRESP of the accepting port to the master, with an optional built-in default slave for unmapped addresses.

## Interface
- `ADDR_WIDTH`, 32, address width
- `NUM_OUT`, 4, number of output ports (1..8)

- `HCLK`  in  1  AHB clock
- `HRESETn`  in  1  Reset: asynchronous, active-low; clock HCLK.
- `HSELS, HTRANSS[1:0], HADDRS, HWRITES, HSIZES[2:0], HBURSTS[2:0], HPROTS[3:0], HMASTLOCKS`  in  –  master address phase
- `HREADYS`  in  1  master-side bus ready
- `HREADYOUTS`  out  1  ready to master
- `HRESPS`  out  1  response to master (0 OKAY, 1 ERROR)
- `HTRANSM, HADDRM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM`  out  –  address phase to output ports (held or live)
- `targ_sel`  in  NUM_OUT  one-hot decode of `HADDRM` (external decoder); all-zero means unmapped
- `req_port`  out  NUM_OUT  request to each output arbiter
- `addr_accept`  in  NUM_OUT  output port i samples our address this cycle (arbiter selected us and its HREADYM=1)
- `data_readyout`  in  NUM_OUT  per-port data-phase HREADYOUT
- `data_resp`  in  NUM_OUT  per-port data-phase HRESP

## Operation
- Live transfer: `xfer_s = HSELS & HTRANSS[1] & HREADYS`.
- Mux: when `hold_valid`=1, the M-side outputs carry the held registers. Otherwise they carry the live inputs, with HTRANSM forced to IDLE when `~HSELS | ~HREADYS`.
- `req_port = targ_sel & {NUM_OUT{HTRANSM[1]}}`. When `HMASTLOCKM` is high, req stays on for IDLE as well.
- Capture: if `xfer_s` and `~|(addr_accept & targ_sel)`, latch all address-phase signals and set `hold_valid`.
- Release: when `hold_valid` and `|(addr_accept & targ_sel)`, clear `hold_valid`.
- Data-phase tracker:
  - `dphase_port` (one-hot) and `dphase_valid` load on any accept (live or held).
  - They clear when `HREADYS` completes the data phase and no new accept occurs.
- HREADYOUTS priority:
  - `dphase_valid` → `|(data_readyout & dphase_port)`.
  - else `hold_valid` → 0.
  - else 1.
- HRESPS = `|(data_resp & dphase_port)` when `dphase_valid`, else 0.
- IDLE/BUSY transfers: never captured, never requested; the master gets a zero-wait OKAY.
- States (implicit in `{hold_valid, dphase_valid}`):
  - IDLE (00)
  - HOLD (10)
  - DATA (01)
  - DATA+next-live (01, new accept)
  - 11 is unreachable; a simulation assertion checks this.

## Timing
- Reset values:
  - `hold_valid`=0, `dphase_valid`=0, `dphase_port`=0
  - HREADYOUTS=1, HRESPS=0, `req_port`=0, HTRANSM=IDLE
- Accepted in the same cycle: zero added latency, and the address passes combinationally.
- Held transfer: presented from the cycle after capture. The master sees HREADYOUTS=0 until the data phase of that transfer completes.
- Simultaneous capture of a new live transfer and completion of the previous data phase: the capture wins and `dphase_valid` clears.
- Reset mid-hold: the held transfer is discarded and nothing is presented afterwards.
- ERROR is passed through cycle-exact from the port (two-cycle response).

## Configuration
- `AHB_MTX_INSTAGE_DEFSLAVE_EN` defined:
  - A valid transfer with `targ_sel`=0 is accepted internally at once.
  - Response: cycle 1 HREADYOUTS=0/HRESPS=1, cycle 2 HREADYOUTS=1/HRESPS=1.
- Undefined:
  - Default-slave logic is removed.
  - `targ_sel`=0 with HTRANSM[1]=1 is illegal: simulation `$error`, and the transfer stays held.

## Structure
- Shared `ahb_mtx_pkg` holds:
  - HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
  - HBURST encodings
  - HRESP OKAY/ERROR
- One sub-module: `ahb_mtx_defslave_resp`, the two-cycle ERROR FSM (states OKAY, ERR1, ERR2), instantiated only under the macro.

## Test plan
- NONSEQ to port 1 with `addr_accept[1]` same cycle → no capture, HREADYOUTS follows `data_readyout[1]` next cycle, `req_port`=4'b0010.
- NONSEQ to port 2 while `addr_accept`=0 for 3 cycles → `hold_valid`=1, HADDRM=held value, HREADYOUTS=0 until the accept plus data-phase ready.
- INCR4 burst with accept delayed only on beat 1 → beats 2–4 pass live, each with exactly one wait state from the port.
- `data_resp[0]` two-cycle ERROR → HRESPS=1 for 2 cycles, HREADYOUTS 0 then 1.
- Unmapped NONSEQ (`targ_sel`=0) with the macro on → ERR1/ERR2 response, `req_port`=0.
- HRESETn low while holding → all outputs at reset values, no `req_port` after release.
